sample_ram_arbiter: RTL
=======================

SAMPLE_RAM_ARBITER -- requirements
Module: sample_ram_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 9, sample RAM address width; DATA_W, 8, sample width; STARVE_LIMIT, 16, maximum consecutive denied cycles for port 1 in fixed-priority mode.
REQ-002 clk  input  1  the single clock; every register SHALL update on its rising edge.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 rd0_req  input  1  port 0 (wave display) read request, held until granted.
REQ-005 rd0_addr  input  ADDR_W  port 0 read address, stable while rd0_req is high.
REQ-006 rd0_gnt  output  1  port 0 grant, combinational, in the request cycle.
REQ-007 rd0_data  output  DATA_W  port 0 returned sample, registered.
REQ-008 rd0_valid  output  1  one-cycle pulse, rd0_data is new.
REQ-009 rd1_req, rd1_addr, rd1_gnt, rd1_data, rd1_valid SHALL be the same as REQ-004..008 for port 1 (secondary reader).
REQ-010 ram_addr  output  ADDR_W  drives the RAM read port address (addrb).
REQ-011 ram_dout  input  DATA_W  RAM read data, valid one cycle after the address is sampled.

Function
REQ-012 At most one of rd0_gnt and rd1_gnt SHALL be high in any cycle; a grant SHALL be issued only to a port whose request is high.
REQ-013 ram_addr SHALL be registered: on a grant it loads the granted port's address; with no grant it holds its value.
REQ-014 Latency: grant in cycle T; ram_dout is valid in T+1; rdN_data is loaded from ram_dout at the end of T+1; rdN_valid is high for exactly cycle T+2.
REQ-015 A 2-deep in-flight tag pipeline (valid bit plus port id) SHALL route each return to the granting port; back-to-back grants every cycle SHALL be sustained with no bubbles.
REQ-016 rdN_data SHALL hold its value between rdN_valid pulses.
REQ-017 Fixed-priority mode: port 0 wins when both ports request, unless the starvation counter equals STARVE_LIMIT. In that case port 1 is granted for one cycle.
REQ-018 The starvation counter SHALL increment on each cycle with rd1_req high and rd1_gnt low, and clear on rd1_gnt or when rd1_req is low. It SHALL saturate at STARVE_LIMIT.
REQ-019 With a single requester, that requester SHALL be granted in the same cycle.
REQ-020 If a requester deasserts rdN_req before it is granted, the arbiter SHALL drop the request with no return; this is not an error.

Reset
REQ-021 While reset is low at a clock edge, the following SHALL clear to 0: rd0_gnt, rd1_gnt, rd0_valid, rd1_valid, rd0_data, rd1_data, ram_addr, the tag pipeline, the starvation counter, and the RR pointer (points to port 0).
REQ-022 Grants SHALL be forced low during reset, and any in-flight return SHALL be discarded (no valid pulse after reset releases).

Configuration
REQ-023 With SAMPLE_ARB_RR_EN defined, arbitration SHALL be round-robin. On a conflict, the port not granted most recently wins, and the pointer updates on every grant. The starvation counter and STARVE_LIMIT SHALL then be unused.
REQ-024 With SAMPLE_ARB_RR_EN undefined, REQ-017/018 fixed priority with the starvation guard SHALL apply.

Structure
REQ-025 The shared package SHALL hold ADDR_W and DATA_W defaults, the port-id encoding (PORT0=0, PORT1=1), and the in-flight tag struct {valid, port}.
REQ-026 Grant selection SHALL be one sub-module, sample_arb_pick (combinational: reqs, pointer/starve state -> one-hot grant); all state stays in sample_ram_arbiter.

Verification
REQ-027 Only rd0_req=1 with addr 0x05, RAM model returning addr+1 -> rd0_gnt is high in T, rd0_valid in T+2, rd0_data=0x06, rd1_valid never asserts.
REQ-028 Both ports request every cycle, fixed priority, STARVE_LIMIT=16 -> port 1 is granted exactly once every 17 cycles; all other grants go to port 0.
REQ-029 Same stimulus with SAMPLE_ARB_RR_EN -> grants alternate 0,1,0,1; each return matches its own address.
REQ-030 rd0_req held for 300 consecutive cycles with addresses 0..299 -> 300 rd0_valid pulses in order, with no gaps after the first.
REQ-031 Reset driven low in the cycle after a grant -> no rdN_valid pulse afterwards; all outputs read 0 on release.
REQ-032 rd1_req pulsed for one cycle while port 0 holds priority (fixed mode) -> rd1_gnt stays low, rd1_valid never asserts, and the starvation counter returns to 0.

Source files
------------

// File: rtl/sample_ram_arbiter_pkg.sv
// rtl/sample_ram_arbiter_pkg.sv - shared widths, port ids and in-flight tag type for the sample RAM arbiter
package sample_ram_arbiter_pkg;

  localparam int ADDR_W_DEF = 9;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e port;
  } tag_t;

endpackage

// File: rtl/sample_ram_arbiter_if.sv
// rtl/sample_ram_arbiter_if.sv - two read ports plus the RAM read port of the sample RAM arbiter
interface sample_ram_arbiter_if
  import sample_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);
  logic              rd0_req;
  logic [ADDR_W-1:0] rd0_addr;
  logic              rd0_gnt;
  logic [DATA_W-1:0] rd0_data;
  logic              rd0_valid;
  logic              rd1_req;
  logic [ADDR_W-1:0] rd1_addr;
  logic              rd1_gnt;
  logic [DATA_W-1:0] rd1_data;
  logic              rd1_valid;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;

  // readers and the RAM model sit on the master side
  modport master (
    output rd0_req, rd0_addr, rd1_req, rd1_addr, ram_dout,
    input  rd0_gnt, rd0_data, rd0_valid, rd1_gnt, rd1_data, rd1_valid, ram_addr
  );

  modport slave (
    input  rd0_req, rd0_addr, rd1_req, rd1_addr, ram_dout,
    output rd0_gnt, rd0_data, rd0_valid, rd1_gnt, rd1_data, rd1_valid, ram_addr
  );
endinterface

// File: rtl/sample_arb_pick.sv
// rtl/sample_arb_pick.sv - combinational one-hot grant select; prio1 says port 1 wins a conflict
module sample_arb_pick (
  input  logic [1:0] req,
  input  logic       prio1,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!req[1] || !prio1)) begin
      gnt = 2'b01;
    end else if (req[1]) begin
      gnt = 2'b10;
    end
  end
endmodule

// File: rtl/sample_ram_arbiter.sv
// rtl/sample_ram_arbiter.sv - two-reader arbiter for the sample RAM read port
// SAMPLE_ARB_RR_EN selects round-robin; otherwise fixed priority with a port-1 starvation guard.
module sample_ram_arbiter
  import sample_ram_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 16
) (
  input logic                 clk,
  input logic                 reset,
  sample_ram_arbiter_if.slave bus
);
  logic [1:0]        req;
  logic [1:0]        gnt_raw;
  logic [1:0]        gnt;
  logic              prio1;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] rd0_data_q;
  logic [DATA_W-1:0] rd1_data_q;
  tag_t              tag0;
  tag_t              tag1;

  assign req = {bus.rd1_req, bus.rd0_req};

  sample_arb_pick u_pick (
    .req   (req),
    .prio1 (prio1),
    .gnt   (gnt_raw)
  );

  assign gnt         = gnt_raw & {2{reset}};
  assign bus.rd0_gnt = gnt[0];
  assign bus.rd1_gnt = gnt[1];

`ifdef SAMPLE_ARB_RR_EN
  // rr_ptr names the port that wins the next conflict
  logic rr_ptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr <= 1'b0;
    end else if (gnt[0]) begin
      rr_ptr <= 1'b1;
    end else if (gnt[1]) begin
      rr_ptr <= 1'b0;
    end
  end

  assign prio1 = rr_ptr;
`else
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  logic [SW-1:0] starve_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt <= '0;
    end else if (req[1] && !gnt[1]) begin
      if (starve_cnt != SW'(STARVE_LIMIT)) begin
        starve_cnt <= starve_cnt + SW'(1);
      end
    end else begin
      starve_cnt <= '0;
    end
  end

  assign prio1 = (starve_cnt == SW'(STARVE_LIMIT));
`endif

  // tag0 tracks the cycle ram_dout is valid, tag1 the cycle the return is presented
  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_addr_q <= '0;
      rd0_data_q <= '0;
      rd1_data_q <= '0;
      tag0       <= '0;
      tag1       <= '0;
    end else begin
      if (gnt[1]) begin
        ram_addr_q <= bus.rd1_addr;
      end else if (gnt[0]) begin
        ram_addr_q <= bus.rd0_addr;
      end
      tag0 <= '{valid: |gnt, port: (gnt[1] ? PORT1 : PORT0)};
      tag1 <= tag0;
      if (tag0.valid && tag0.port == PORT0) begin
        rd0_data_q <= bus.ram_dout;
      end
      if (tag0.valid && tag0.port == PORT1) begin
        rd1_data_q <= bus.ram_dout;
      end
    end
  end

  assign bus.ram_addr  = ram_addr_q;
  assign bus.rd0_data  = rd0_data_q;
  assign bus.rd1_data  = rd1_data_q;
  assign bus.rd0_valid = tag1.valid && (tag1.port == PORT0);
  assign bus.rd1_valid = tag1.valid && (tag1.port == PORT1);
endmodule
